// File: rtl/ring_osc_pkg.sv
// Shared types and helpers for the ring-oscillator bank: measurement FSM
// states and the ring-length decode used by every channel.
package ring_osc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_COUNT,
    ST_DONE
  } osc_state_e;

  localparam int unsigned MIN_STAGES = 3;

  // Odd ring length 2*cfg+3, clamped to the physical chain length.
  function automatic int unsigned stage_len(input int unsigned cfg,
                                            input int unsigned max_stages);
    int unsigned len;
    len = 2 * cfg + MIN_STAGES;
    return (len > max_stages) ? max_stages : len;
  endfunction

endpackage

// File: rtl/ring_osc_channel.sv
// One inverting ring modelled as a Johnson chain. Length is captured when the
// ring starts, so stage_cfg edits only take effect on the next restart.
module ring_osc_channel
  import ring_osc_pkg::*;
#(
  parameter int MAX_STAGES = 15,
  parameter int STG_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [STG_W-1:0] stage_cfg,
  output logic             tap
);

  localparam int LEN_W = $clog2(MAX_STAGES + 1);

  logic [MAX_STAGES-1:0] s, s_nxt;
  logic [LEN_W-1:0]      len_q, len_eff, cfg_len;
  logic                  run_q;
  logic                  start_run;

  assign cfg_len   = LEN_W'(stage_len(32'(stage_cfg), MAX_STAGES));
  assign start_run = run && !run_q;
  // On the first run cycle the chain is all-zero, so using the fresh length
  // immediately keeps the first rise exactly L clocks out.
  assign len_eff   = start_run ? cfg_len : len_q;

  always_comb begin
    s_nxt = '0;
    if (run) begin
      s_nxt = {s[MAX_STAGES-2:0], ~s[len_eff - 1'b1]};
      for (int i = 0; i < MAX_STAGES; i++)
        if (i >= int'(len_eff)) s_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s     <= '0;
      run_q <= 1'b0;
      len_q <= LEN_W'(MIN_STAGES);
    end else begin
      s     <= s_nxt;
      run_q <= run;
      if (start_run) len_q <= cfg_len;
    end
  end

  assign tap = s[len_q - 1'b1];

endmodule

// File: rtl/ring_osc_bank.sv
// Bank of NUM_CH ring oscillators plus a gated-window rising-edge counter
// that characterises one selected tap under a start/done handshake.
module ring_osc_bank
  import ring_osc_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int MAX_STAGES = 15,
  parameter  int STG_W      = 3,
  parameter  int CNT_W      = 16,
  parameter  int WIN_W      = 16,
  localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [STG_W-1:0]  stage_cfg,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [WIN_W-1:0]  window,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic [NUM_CH-1:0] ro_out
);

  localparam int PAD_W = 1 << SEL_W;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ring_osc_channel #(
      .MAX_STAGES(MAX_STAGES),
      .STG_W     (STG_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (enable & ch_en[c]),
      .stage_cfg(stage_cfg),
      .tap      (ro_out[c])
    );
  end

  osc_state_e       state, state_nxt;
  logic [SEL_W-1:0] sel_q;
  logic [WIN_W-1:0] win_cnt;
  logic             prev_tap;
  logic             tap_sel;
  logic [PAD_W-1:0] tap_pad;
  logic             rise;

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    tap_pad             = '0;
    tap_pad[NUM_CH-1:0] = ro_out;
    tap_sel             = (32'(sel_q) < NUM_CH) ? tap_pad[sel_q] : ro_out[0];
  end

  assign rise = !prev_tap && tap_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start && enable) state_nxt = ST_ARM;
      ST_ARM:   state_nxt = (win_cnt == '0) ? ST_DONE : ST_COUNT;
      ST_COUNT: if (win_cnt == WIN_W'(1)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    // Dropping enable aborts without a done pulse.
    if (!enable) state_nxt = ST_IDLE;
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE) && enable;

  // Datapath freezes while enable is low so partial results are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      win_cnt  <= '0;
      prev_tap <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (enable) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel_q   <= ch_sel;
            win_cnt <= window;
          end
        end
        ST_ARM: begin
          count    <= '0;
          overflow <= 1'b0;
          prev_tap <= tap_sel;
        end
        ST_COUNT: begin
          prev_tap <= tap_sel;
          win_cnt  <= win_cnt - 1'b1;
          if (rise) begin
            if (count == '1) overflow <= 1'b1;
            else             count    <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_osc_bank.sv
// Self-checking bench for ring_osc_bank: measurement table, directed corner
// sequences and a randomized run against a cycle-indexed reference model.
module tb_ring_osc_bank;

  localparam int NCH  = 3;
  localparam int MAXS = 15;
  localparam int STGW = 3;
  localparam int CNTW = 4;
  localparam int WINW = 16;
  localparam int SELW = 2;
  localparam int CMAX = (1 << CNTW) - 1;
  localparam int HN   = 8192;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic [NCH-1:0]  ch_en = '0;
  logic [STGW-1:0] stage_cfg = '0;
  logic [SELW-1:0] ch_sel = '0;
  logic [WINW-1:0] window = '0;
  logic            start = 1'b0;
  logic            busy, done, overflow;
  logic [CNTW-1:0] count;
  logic [NCH-1:0]  ro_out;
  bit              clk_hold = 1'b0;

  always begin
    #5;
    if (!clk_hold) clk = ~clk;
  end

  ring_osc_bank #(
    .NUM_CH(NCH), .MAX_STAGES(MAXS), .STG_W(STGW), .CNT_W(CNTW), .WIN_W(WINW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_en(ch_en),
    .stage_cfg(stage_cfg), .ch_sel(ch_sel), .window(window), .start(start),
    .busy(busy), .done(done), .count(count), .overflow(overflow),
    .ro_out(ro_out)
  );

  int nchk = 0;
  int nerr = 0;

  // Reference model: each running ring is a square wave of half-period L
  // that starts low on its first run cycle; a measurement samples cycles
  // start+2 .. start+window+1 against the previous cycle's tap.
  int             t = 0;
  bit             running [NCH];
  int             t0 [NCH];
  int             len [NCH];
  logic [NCH-1:0] hist [HN];
  bit             act;
  int             ts, wl, msel;
  int             hold_cnt;
  bit             hold_ovf;

  logic [NCH-1:0]  s_ro;
  logic            s_busy, s_done, s_ovf;
  logic [CNTW-1:0] s_cnt;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", nm, t, got, exp);
    end
  endtask

  function automatic int model_len(input int cfg);
    return (2 * cfg + 3 > MAXS) ? MAXS : 2 * cfg + 3;
  endfunction

  function automatic int edges(input int a, input int b, input int ch);
    int n = 0;
    for (int j = a; j <= b; j++)
      if (!hist[(j - 1) % HN][ch] && hist[j % HN][ch]) n++;
    return n;
  endfunction

  function automatic int sat(input int e);
    return (e > CMAX) ? CMAX : e;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) running[c] = 1'b0;
    act = 1'b0;
    hold_cnt = 0;
    hold_ovf = 1'b0;
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model with the
  // inputs currently applied, then move to just after the next rising edge.
  task automatic cyc();
    logic [NCH-1:0] et;
    int e;
    @(negedge clk);
    for (int c = 0; c < NCH; c++)
      et[c] = running[c] && (((t - t0[c]) / len[c]) % 2 == 1);
    hist[t % HN] = et;
    s_ro = ro_out; s_busy = busy; s_done = done; s_cnt = count; s_ovf = overflow;
    chk("ro_out", ro_out, et);
    chk("busy", busy, act && t >= ts + 1);
    chk("done", done, act && t == ts + wl + 2 && enable);
    if (!act || t <= ts + 1) begin
      chk("count_hold", count, hold_cnt);
      chk("ovf_hold", overflow, hold_ovf);
    end else if (t == ts + wl + 2) begin
      e = edges(ts + 2, ts + wl + 1, msel);
      chk("count_final", count, sat(e));
      chk("ovf_final", overflow, e > CMAX);
    end
    for (int c = 0; c < NCH; c++) begin
      if (enable && ch_en[c] && !running[c]) begin
        running[c] = 1'b1; t0[c] = t; len[c] = model_len(int'(stage_cfg));
      end else if (!(enable && ch_en[c])) begin
        running[c] = 1'b0;
      end
    end
    if (act && !enable) begin
      act = 1'b0;
      if (t > ts + 1) begin
        e = edges(ts + 2, (t - 1 < ts + wl + 1) ? t - 1 : ts + wl + 1, msel);
        hold_cnt = sat(e); hold_ovf = e > CMAX;
      end
    end else if (act && t == ts + wl + 2) begin
      act = 1'b0;
      e = edges(ts + 2, ts + wl + 1, msel);
      hold_cnt = sat(e); hold_ovf = e > CMAX;
    end else if (!act && start && enable) begin
      act = 1'b1; ts = t; wl = int'(window);
      msel = (int'(ch_sel) < NCH) ? int'(ch_sel) : 0;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  // Runs n cycles and reports the offsets of the first two rises of ro_out[0].
  task automatic rises(input int n, output int r1, output int r2);
    logic prev;
    r1 = -1; r2 = -1; prev = s_ro[0];
    for (int k = 0; k < n; k++) begin
      cyc();
      if (!prev && s_ro[0]) begin
        if (r1 < 0) r1 = k;
        else if (r2 < 0) r2 = k;
      end
      prev = s_ro[0];
    end
  endtask

  typedef struct {
    int cfg;
    int sel;
    int win;
    int exp_cnt;
    int exp_ovf;
  } row_t;

  row_t rows [9];

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish (errors so far %0d)", nerr);
    $fatal(1);
  end

  initial begin
    int lat, r1, r2, n;
    bit got;

    // Fresh ring, start on the first run cycle: count = number of odd
    // multiples of L within 2..window+1, saturating at 15.
    rows[0] = '{0, 0,  60, 10, 0};
    rows[1] = '{0, 0,   0,  0, 0};
    rows[2] = '{0, 0, 120, 15, 1};
    rows[3] = '{0, 0,  12,  2, 0};
    rows[4] = '{1, 1,  40,  4, 0};
    rows[5] = '{6, 2, 100,  3, 0};
    rows[6] = '{7, 3,  29,  1, 0};
    rows[7] = '{2, 2,   1,  0, 0};
    rows[8] = '{3, 1,  18,  1, 0};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ro", ro_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_count", count, 0);
    chk("reset_ovf", overflow, 0);
    rst_n = 1'b1;

    for (int r = 0; r < 9; r++) begin
      enable = 1'b0; start = 1'b0;
      cyc();
      enable = 1'b1; ch_en = '1;
      stage_cfg = STGW'(rows[r].cfg);
      ch_sel = SELW'(rows[r].sel);
      window = WINW'(rows[r].win);
      start = 1'b1;
      cyc();
      start = 1'b0;
      lat = 0; got = 1'b0;
      while (!got && lat < rows[r].win + 8) begin
        cyc();
        lat++;
        got = s_done;
      end
      chk("row_done_seen", got, 1);
      chk("row_latency", lat, rows[r].win + 2);
      chk("row_count", s_cnt, rows[r].exp_cnt);
      chk("row_ovf", s_ovf, rows[r].exp_ovf);
    end

    // Ring period and first-rise timing, then length clamp.
    enable = 1'b0; ch_en = '0;
    cyc();
    enable = 1'b1; ch_en = 3'b001; stage_cfg = 3'd0;
    rises(30, r1, r2);
    chk("first_rise_L3", r1, 3);
    chk("period_L3", r2 - r1, 6);
    ch_en = '0;
    cyc();
    stage_cfg = 3'd6; ch_en = 3'b001;
    rises(70, r1, r2);
    chk("first_rise_L15", r1, 15);
    chk("period_L15", r2 - r1, 30);

    // Length edits while running wait for a restart.
    stage_cfg = 3'd0;
    rises(70, r1, r2);
    chk("period_held", r2 - r1, 30);
    ch_en = '0;
    cyc();
    ch_en = 3'b001;
    rises(12, r1, r2);
    chk("restart_first_rise", r1, 3);
    chk("restart_period", r2 - r1, 6);

    // Second start while busy is dropped.
    ch_en = '1; window = 16'd20; ch_sel = 2'd1; start = 1'b1;
    cyc();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      start = (i == 5);
      cyc();
      if (s_done) n++;
    end
    start = 1'b0;
    chk("single_done", n, 1);

    // Enable dropped mid-count: abort, rings cleared, no done.
    window = 16'd50; ch_sel = 2'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (10) cyc();
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    cyc();
    chk("abort_busy", s_busy, 0);
    chk("abort_rings", s_ro, 0);
    n = 0;
    repeat (60) begin
      cyc();
      if (s_done) n++;
    end
    chk("abort_no_done", n, 0);

    // Selected channel switched off mid-measurement.
    ch_sel = 2'd2; window = 16'd60; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (20) cyc();
    ch_en = 3'b011;
    repeat (50) cyc();
    ch_en = '1;

    // Asynchronous reset while busy, including with the clock stalled.
    enable = 1'b0;
    cyc();
    enable = 1'b1; stage_cfg = 3'd0; window = 16'd50; ch_sel = 2'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (10) cyc();
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_ro", ro_out, 0);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_count", count, 0);
    chk("midrun_rst_done", done, 0);
    clk_hold = 1'b1;
    #50;
    chk("stall_rst_ro", ro_out, 0);
    chk("stall_rst_busy", busy, 0);
    chk("stall_rst_count", count, 0);
    chk("stall_rst_ovf", overflow, 0);
    clk_hold = 1'b0;
    enable = 1'b0; ch_en = '0; start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Randomized traffic against the model.
    ch_en = '1;
    repeat (1500) begin
      enable = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 19) == 0) ch_en = NCH'($urandom);
      if ($urandom_range(0, 9) == 0) stage_cfg = STGW'($urandom);
      start = ($urandom_range(0, 7) == 0);
      window = WINW'($urandom_range(0, 40));
      ch_sel = SELW'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ring_osc_bank.md
Name: ring_osc_bank

Overview:
Parametrised multi-channel ring-oscillator model with a built-in frequency counter. It is the successor to the single 5-stage clocked ring.
- Each channel is an inverting ring with a runtime-selectable odd length, modelled as a Johnson chain: one inversion, one clock of delay per stage.
- A gated-window edge counter measures any one channel's tap frequency under a start/done handshake.
- Sits beside the scaler datapath as an on-chip timing/characterisation monitor.

Parameters:
NUM_CH, 4, number of ring channels (>=1)
MAX_STAGES, 15, maximum ring length; odd, >=3
STG_W, 3, width of stage_cfg
CNT_W, 16, edge-count width
WIN_W, 16, measurement-window width in clk cycles

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  global enable; low clears all rings and aborts measurement
ch_en  input  NUM_CH  per-channel run enable
stage_cfg  input  STG_W  ring length select; L = min(2*stage_cfg+3, MAX_STAGES)
ch_sel  input  clog2(NUM_CH) (min 1)  channel to measure
window  input  WIN_W  measurement length in cycles
start  input  1  measurement request, single-cycle pulse
busy  output  1  measurement in progress
done  output  1  one-cycle pulse, count valid
count  output  CNT_W  rising edges seen in window (saturating)
overflow  output  1  count saturated in last measurement
ro_out  output  NUM_CH  tap of each ring (stage L-1)

Behaviour:
- Reset (rst_n low, async): all stage bits 0, ro_out 0, FSM IDLE, busy 0, done 0, count 0, overflow 0; latched L per channel = 3.
- Channel ring, state s[MAX_STAGES-1:0]:
  - Running when enable & ch_en[c]: s[0] <= ~s[L-1]; s[i] <= s[i-1] for 1 <= i < L; bits >= L held 0.
  - ro_out[c] = s[L-1], registered.
  - Period 2L clocks, 50% duty. From all-zero, first ro_out rise occurs L clocks after first run cycle.
- Channel stop: if ch_en[c] or enable is low, s cleared to 0 on the next clk.
- Length latch: L is latched only on the cycle a channel's run condition goes 0->1. stage_cfg changes while running are ignored until the next restart.
- FSM states IDLE, ARM, COUNT, DONE:
  - IDLE: busy=0. On start & enable, latch ch_sel and window, then go to ARM.
  - ARM (1 cycle): count<=0, overflow<=0, prev_tap<=selected tap, win_cnt<=window. If window==0, go to DONE; else go to COUNT.
  - COUNT: each cycle, a rising edge (prev_tap==0 & tap==1) increments count. prev_tap updates every cycle. win_cnt decrements; on the cycle win_cnt==1, go to DONE (exactly `window` sample cycles).
  - DONE (1 cycle): done=1, then IDLE.
  - busy=1 in ARM, COUNT and DONE.
- Handshake: start is sampled only in IDLE; start while busy is ignored, with no queueing. done rises exactly window+2 cycles after the start cycle (window=0: 2 cycles).
- Saturation: count holds at 2^CNT_W-1; a further edge sets overflow. count and overflow hold until the next ARM.
- Selected channel disabled mid-measurement: measurement continues and counts no further edges.
- enable low during ARM/COUNT/DONE: FSM returns to IDLE next cycle with no done pulse; count and overflow hold their partial values.
- ch_sel >= NUM_CH: measures tap 0.

Decomposition:
- Package ring_osc_pkg: FSM state enum; function stage_len(stage_cfg, MAX_STAGES) returning the clamped odd L; width constants.
- Sub-module ring_osc_channel: one ring with latched length, run/clear logic and tap. ring_osc_bank instantiates NUM_CH of these via generate, plus the FSM and counter.

Test Plan:
- Reset mid-run: assert rst_n low while busy with rings toggling -> immediately ro_out=0, busy=0, count=0; a stalled clock still shows reset values.
- stage_cfg=0 (L=3), ch_en[0]=1 for 30 cycles -> ro_out[0] first rises at cycle 3, period 6; stage_cfg=6 clamps to L=15, period 30.
- Ring 0 with L=3 running, start with ch_sel=0, window=60 -> done at start+62, count=10, overflow=0; repeat with window=0 -> done at start+2, count=0.
- CNT_W=4, L=3, window=120 -> count=15, overflow=1. A second start with window=12 -> count=2, overflow=0.
- start pulsed again 5 cycles into an active measurement -> ignored; exactly one done. Change stage_cfg while running -> period unchanged until ch_en is toggled.
- enable dropped mid-COUNT -> busy falls next cycle, no done, all rings cleared; ch_sel=NUM_CH measures channel 0.
